// File: rtl/pipeline_run_ctrl.sv
// Execution controller for the MIPS pipeline: turns debugger run/step/stop commands,
// PC breakpoints and HALT instructions into per-stage advance enables with a drain phase.
module pipeline_run_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int NUM_STAGES = 5,
  parameter int NUM_BP     = 4,
  parameter int STEP_W     = 16,
  parameter int CNT_W      = 32,
  localparam int BP_IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [2:0]            i_cmd,
  input  logic [STEP_W-1:0]     i_cmd_arg,
  input  logic [BP_IDX_W-1:0]   i_bp_idx,
  input  logic [PC_WIDTH-1:0]   i_bp_addr,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_halt_instr,
  input  logic [NUM_STAGES-1:0] i_stage_valid,
  output logic                  o_fetch_en,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic                  o_running,
  output logic                  o_halted,
  output logic [2:0]            o_halt_cause,
  output logic [BP_IDX_W-1:0]   o_bp_hit_idx,
  output logic                  o_cmd_err,
  output logic [CNT_W-1:0]      o_cycle_count
);

  // Command handshake: i_cmd_valid is a one-cycle strobe with no ready; every
  // non-NOP command is either accepted that cycle or flagged by o_cmd_err next cycle.
  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_RUN    = 3'd1;
  localparam logic [2:0] CMD_STOP   = 3'd2;
  localparam logic [2:0] CMD_STEP   = 3'd3;
  localparam logic [2:0] CMD_SET_BP = 3'd4;
  localparam logic [2:0] CMD_CLR_BP = 3'd5;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_STEP = 3'd1;
  localparam logic [2:0] CAUSE_BP   = 3'd2;
  localparam logic [2:0] CAUSE_HALT = 3'd3;
  localparam logic [2:0] CAUSE_STOP = 3'd4;

  localparam int DCNT_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES - 1) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(NUM_STAGES - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t                state;
  logic [STEP_W-1:0]     step_cnt;
  logic [DCNT_W-1:0]     drain_cnt;
  logic                  bp_suppress;
  logic [NUM_BP-1:0]     bp_valid;
  logic [PC_WIDTH-1:0]   bp_addr [NUM_BP];

  logic                  advancing;
  logic                  start_ok;
  logic                  run_acc, step_acc, stop_acc, set_bp, clr_bp;
  logic                  cmd_illegal;
  logic                  bp_match, bp_ev, halt_ev, halt_any;
  logic [BP_IDX_W-1:0]   bp_match_idx;

  // Stage 0 occupancy is irrelevant: fetch is already bubbled while draining.
  logic unused_stage0;
  assign unused_stage0 = i_stage_valid[0];

  assign advancing = (state == S_RUN) || (state == S_STEP);
  assign start_ok  = (state == S_IDLE) || (state == S_HALTED);

  assign run_acc  = i_cmd_valid && (i_cmd == CMD_RUN) && start_ok;
  assign step_acc = i_cmd_valid && (i_cmd == CMD_STEP) && start_ok;
  assign stop_acc = i_cmd_valid && (i_cmd == CMD_STOP) && advancing;
  assign set_bp   = i_cmd_valid && (i_cmd == CMD_SET_BP);
  assign clr_bp   = i_cmd_valid && (i_cmd == CMD_CLR_BP);

  assign cmd_illegal = i_cmd_valid && (i_cmd != CMD_NOP) &&
                       !(run_acc || step_acc || stop_acc || set_bp || clr_bp);

  // Scan from the top so the lowest matching entry is the one left standing.
  always_comb begin
    bp_match     = 1'b0;
    bp_match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_valid[i] && (bp_addr[i] == i_pc)) begin
        bp_match     = 1'b1;
        bp_match_idx = BP_IDX_W'(i);
      end
    end
  end

  assign bp_ev    = advancing && !bp_suppress && bp_match;
  assign halt_ev  = advancing && i_halt_instr;
  assign halt_any = stop_acc || bp_ev || halt_ev;

  // A halt event blocks fetch in the same cycle so the offending PC never enters IF.
  always_comb begin
    o_fetch_en = 1'b0;
    o_stage_en = '0;
    if (advancing && !halt_any) begin
      o_fetch_en = 1'b1;
      o_stage_en = '1;
    end else if (advancing || (state == S_DRAIN)) begin
      o_stage_en    = '1;
      o_stage_en[0] = 1'b0;
    end
  end

  assign o_running = advancing || (state == S_DRAIN);
  assign o_halted  = (state == S_HALTED);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      step_cnt      <= '0;
      drain_cnt     <= '0;
      bp_suppress   <= 1'b0;
      bp_valid      <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
      o_halt_cause  <= CAUSE_NONE;
      o_bp_hit_idx  <= '0;
      o_cmd_err     <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_cmd_err <= cmd_illegal;
      if (|o_stage_en) o_cycle_count <= o_cycle_count + CNT_W'(1);

      for (int i = 0; i < NUM_BP; i++) begin
        if (set_bp && (i_bp_idx == BP_IDX_W'(i))) begin
          bp_valid[i] <= 1'b1;
          bp_addr[i]  <= i_bp_addr;
        end else if (clr_bp && (i_bp_idx == BP_IDX_W'(i))) begin
          bp_valid[i] <= 1'b0;
        end
      end

      case (state)
        S_IDLE, S_HALTED: begin
          if (run_acc) begin
            state        <= S_RUN;
            o_halt_cause <= CAUSE_NONE;
            bp_suppress  <= 1'b1;
          end else if (step_acc) begin
            state        <= S_STEP;
            step_cnt     <= (i_cmd_arg == '0) ? STEP_W'(1) : i_cmd_arg;
            o_halt_cause <= CAUSE_NONE;
            bp_suppress  <= 1'b1;
          end
        end
        S_RUN, S_STEP: begin
          bp_suppress <= 1'b0;
          if (stop_acc) begin
            state        <= S_DRAIN;
            drain_cnt    <= '0;
            o_halt_cause <= CAUSE_STOP;
          end else if (bp_ev) begin
            state        <= S_DRAIN;
            drain_cnt    <= '0;
            o_halt_cause <= CAUSE_BP;
            o_bp_hit_idx <= bp_match_idx;
          end else if (halt_ev) begin
            state        <= S_DRAIN;
            drain_cnt    <= '0;
            o_halt_cause <= CAUSE_HALT;
          end else if (state == S_STEP) begin
            step_cnt <= step_cnt - STEP_W'(1);
            if (step_cnt == STEP_W'(1)) begin
              state        <= S_HALTED;
              o_halt_cause <= CAUSE_STEP;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DCNT_W'(1);
          if ((i_stage_valid[NUM_STAGES-1:1] == '0) || (drain_cnt == DRAIN_LAST))
            state <= S_HALTED;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: step, breakpoints, resume, HALT drain,
// same-cycle priority, illegal commands and mid-drain reset.
module tb_pipeline_run_ctrl;

  localparam int PC_WIDTH   = 32;
  localparam int NUM_STAGES = 5;
  localparam int NUM_BP     = 4;
  localparam int STEP_W     = 16;
  localparam int CNT_W      = 32;
  localparam int BP_IDX_W   = 2;

  localparam logic [2:0] CMD_RUN    = 3'd1;
  localparam logic [2:0] CMD_STOP   = 3'd2;
  localparam logic [2:0] CMD_STEP   = 3'd3;
  localparam logic [2:0] CMD_SET_BP = 3'd4;

  logic                  clk;
  logic                  rst;
  logic                  cmd_valid;
  logic [2:0]            cmd;
  logic [STEP_W-1:0]     cmd_arg;
  logic [BP_IDX_W-1:0]   bp_idx;
  logic [PC_WIDTH-1:0]   bp_addr;
  logic [PC_WIDTH-1:0]   pc;
  logic                  halt_instr;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  fetch_en;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  running;
  logic                  halted;
  logic [2:0]            halt_cause;
  logic [BP_IDX_W-1:0]   bp_hit_idx;
  logic                  cmd_err;
  logic [CNT_W-1:0]      cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  int fetch_cnt;

  pipeline_run_ctrl #(
    .PC_WIDTH(PC_WIDTH), .NUM_STAGES(NUM_STAGES), .NUM_BP(NUM_BP),
    .STEP_W(STEP_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_cmd_arg(cmd_arg), .i_bp_idx(bp_idx), .i_bp_addr(bp_addr), .i_pc(pc),
    .i_halt_instr(halt_instr), .i_stage_valid(stage_valid),
    .o_fetch_en(fetch_en), .o_stage_en(stage_en), .o_running(running),
    .o_halted(halted), .o_halt_cause(halt_cause), .o_bp_hit_idx(bp_hit_idx),
    .o_cmd_err(cmd_err), .o_cycle_count(cycle_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Command strobe is placed on the next falling edge; returns one cycle later.
  task automatic cmd_pulse(input logic [2:0] c, input logic [STEP_W-1:0] arg,
                           input logic [BP_IDX_W-1:0] idx, input logic [PC_WIDTH-1:0] addr);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_arg   = arg;
    bp_idx    = idx;
    bp_addr   = addr;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  task automatic step_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; cmd_arg = '0; bp_idx = '0;
    bp_addr = '0; pc = '0; halt_instr = 1'b0; stage_valid = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_bp_idx", bp_hit_idx, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_cycles", cycle_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: STEP_N 3 -> exactly three fetch cycles then halted, cause 1
    cmd_pulse(CMD_STEP, 16'd3, 2'd0, 32'h0);
    fetch_cnt = 0;
    #1;
    chk("t1_stage_en", stage_en, 5'b11111);
    for (int i = 0; i < 6; i++) begin
      if (fetch_en) fetch_cnt++;
      @(negedge clk);
      #1;
    end
    chk("t1_fetch_cycles", fetch_cnt, 3);
    chk("t1_halted", halted, 1);
    chk("t1_cause", halt_cause, 1);
    chk("t1_cycles", cycle_count, 3);

    // Test 2: breakpoints at entries 2 and 0 on 0x10, run from PC 0
    cmd_pulse(CMD_SET_BP, 16'd0, 2'd2, 32'h10);
    cmd_pulse(CMD_SET_BP, 16'd0, 2'd0, 32'h10);
    #1;
    chk("t2_setbp_no_err", cmd_err, 0);
    pc = 32'h0;
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t2_run_fetch", fetch_en, 1);
    chk("t2_run_cause_clr", halt_cause, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      pc = 32'(i * 4);
      #1;
      chk("t2_run_fetch_pc", fetch_en, 1);
    end
    @(negedge clk);
    pc = 32'h10;
    #1;
    chk("t2_bp_fetch_off", fetch_en, 0);
    chk("t2_bp_stage_en", stage_en, 5'b11110);
    step_cycle();
    chk("t2_drain_running", running, 1);
    chk("t2_drain_halted", halted, 0);
    chk("t2_drain_stage_en", stage_en, 5'b11110);
    step_cycle();
    chk("t2_halted", halted, 1);
    chk("t2_cause", halt_cause, 2);
    chk("t2_bp_hit_idx", bp_hit_idx, 0);

    // Test 3: resume at the breakpoint PC makes progress, then re-hits later
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t3_resume_fetch", fetch_en, 1);
    @(negedge clk);
    pc = 32'h14;
    #1;
    chk("t3_advance_fetch", fetch_en, 1);
    @(negedge clk);
    pc = 32'h10;
    #1;
    chk("t3_rehit_fetch", fetch_en, 0);
    step_cycle();
    chk("t3_drain_running", running, 1);
    step_cycle();
    chk("t3_halted", halted, 1);
    chk("t3_cause", halt_cause, 2);

    // Test 4: HALT instruction, stage occupancy empties over three drain cycles
    pc = 32'h100;
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t4_run_fetch", fetch_en, 1);
    @(negedge clk);
    halt_instr = 1'b1; stage_valid = 5'b01110;
    #1;
    chk("t4_halt_fetch_off", fetch_en, 0);
    @(negedge clk);
    halt_instr = 1'b0; stage_valid = 5'b01100;
    #1;
    chk("t4_d1_running", running, 1);
    chk("t4_d1_cause", halt_cause, 3);
    @(negedge clk);
    stage_valid = 5'b01000;
    #1;
    chk("t4_d2_halted", halted, 0);
    @(negedge clk);
    stage_valid = 5'b00000;
    #1;
    chk("t4_d3_halted", halted, 0);
    step_cycle();
    chk("t4_halted", halted, 1);
    chk("t4_cause", halt_cause, 3);

    // Test 4b: occupancy never clears -> drain bounded at NUM_STAGES-1 cycles
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    @(negedge clk);
    halt_instr = 1'b1; stage_valid = 5'b11110;
    @(negedge clk);
    halt_instr = 1'b0;
    step_cycle();
    step_cycle();
    step_cycle();
    chk("t4b_d4_halted", halted, 0);
    step_cycle();
    chk("t4b_halted", halted, 1);
    chk("t4b_cycles", cycle_count, 24);
    stage_valid = '0;

    // Test 5: STOP, breakpoint and HALT in the same cycle -> user stop wins
    pc = 32'h200;
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    @(negedge clk);
    pc = 32'h10; halt_instr = 1'b1; cmd_valid = 1'b1; cmd = CMD_STOP;
    #1;
    chk("t5_fetch_off", fetch_en, 0);
    @(negedge clk);
    pc = 32'h200; halt_instr = 1'b0; cmd_valid = 1'b0; cmd = 3'd0;
    #1;
    chk("t5_drain_running", running, 1);
    chk("t5_cause", halt_cause, 4);
    step_cycle();
    chk("t5_halted", halted, 1);

    // Test 5b: two entries match, lowest index is reported
    cmd_pulse(CMD_SET_BP, 16'd0, 2'd3, 32'h20);
    cmd_pulse(CMD_SET_BP, 16'd0, 2'd1, 32'h20);
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    @(negedge clk);
    pc = 32'h20;
    #1;
    chk("t5b_fetch_off", fetch_en, 0);
    step_cycle();
    step_cycle();
    chk("t5b_halted", halted, 1);
    chk("t5b_cause", halt_cause, 2);
    chk("t5b_bp_hit_idx", bp_hit_idx, 1);

    // Test 6: reset during drain, STOP in IDLE, breakpoints lost, RUN while running
    pc = 32'h300;
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    @(negedge clk);
    halt_instr = 1'b1; stage_valid = 5'b11110;
    @(negedge clk);
    halt_instr = 1'b0;
    #1;
    chk("t6_pre_rst_running", running, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_running", running, 0);
    chk("t6_rst_stage_en", stage_en, 0);
    chk("t6_rst_cause", halt_cause, 0);
    chk("t6_rst_bp_idx", bp_hit_idx, 0);
    chk("t6_rst_cycles", cycle_count, 0);
    @(negedge clk);
    rst = 1'b1; stage_valid = '0; pc = 32'h10;
    cmd_pulse(CMD_STOP, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t6_stop_idle_err", cmd_err, 1);
    chk("t6_stop_idle_running", running, 0);
    chk("t6_stop_idle_halted", halted, 0);
    step_cycle();
    chk("t6_err_one_cycle", cmd_err, 0);
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t6_run_fetch", fetch_en, 1);
    step_cycle();
    chk("t6_bp_lost_fetch", fetch_en, 1);
    cmd_pulse(CMD_RUN, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t6_run_in_run_err", cmd_err, 1);
    chk("t6_run_in_run_fetch", fetch_en, 1);
    cmd_pulse(CMD_STOP, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t6_stop_cause", halt_cause, 4);
    cmd_pulse(CMD_STEP, 16'd0, 2'd0, 32'h0);
    #1;
    chk("t6_step0_fetch", fetch_en, 1);
    chk("t6_step0_cause_clr", halt_cause, 0);
    step_cycle();
    chk("t6_step0_halted", halted, 1);
    chk("t6_step0_cause", halt_cause, 1);
    chk("t6_step0_fetch_off", fetch_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
